// File: rtl/lmk_cfg_pkg.sv
// lmk_cfg_pkg: shared types and constants for the LMK04806 MICROWIRE writer.
//   - lmk_state_e : write-engine states
//   - lmk_rom_t   : packed register table (32 words x 32 bits, index = word number)
//   - lmk_debug_t : layout of the 64-bit debug bus
//   - LMK_ROM_DEFAULT / LMK_REG_NUM : board register image and its length
package lmk_cfg_pkg;

    localparam int unsigned LMK_WORD_W    = 32;
    localparam int unsigned LMK_ROM_DEPTH = 32;
    localparam int unsigned LMK_ADDR_W    = 5;
    localparam int unsigned LMK_IDX_W     = 5;
    localparam int unsigned LMK_DEBUG_W   = 64;
    localparam int unsigned LMK_REG_NUM   = 27;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } lmk_state_e;

    typedef logic [LMK_ROM_DEPTH-1:0][LMK_WORD_W-1:0] lmk_rom_t;

    typedef struct packed {
        lmk_state_e            state;
        logic [LMK_ADDR_W-1:0] word_idx;
        logic [LMK_IDX_W-1:0]  bit_idx;
        logic                  lmk_clk;
        logic                  lmk_data;
        logic                  lmk_le;
        logic                  cfg_busy;
        logic                  cfg_done;
        logic [45:0]           rsvd;
    } lmk_debug_t;

    // R0 with the RESET bit set; always the first word so the chip starts clean.
    localparam logic [LMK_WORD_W-1:0] LMK_R0_RESET = 32'h0002_0000;

    // Board register image, write order; low 5 bits of each word are the register address.
    function automatic lmk_rom_t lmk_default_rom();
        lmk_rom_t t;
        t     = '0;
        t[0]  = LMK_R0_RESET;
        t[1]  = 32'h0014_0300;  // R0  CLKout0/1
        t[2]  = 32'h0014_0301;  // R1  CLKout2/3
        t[3]  = 32'h0014_0302;  // R2  CLKout4/5
        t[4]  = 32'h0014_0303;  // R3  CLKout6/7
        t[5]  = 32'h0014_0304;  // R4  CLKout8/9
        t[6]  = 32'h0014_0305;  // R5  CLKout10/11
        t[7]  = 32'h1111_0006;  // R6  output types 0-3
        t[8]  = 32'h1111_0007;  // R7  output types 4-7
        t[9]  = 32'h0101_0008;  // R8  output types 8-11
        t[10] = 32'h5555_5549;  // R9
        t[11] = 32'h9102_410A;  // R10 OSCout
        t[12] = 32'h0401_100B;  // R11 mode / SYNC
        t[13] = 32'h1B0C_006C;  // R12 LD / holdover
        t[14] = 32'h2302_886D;  // R13 readback / CLKin select
        t[15] = 32'h0200_000E;  // R14 CLKin buffers
        t[16] = 32'h8000_800F;  // R15 DAC / holdover
        t[17] = 32'hC155_0410;  // R16 crystal amplitude
        t[18] = 32'h0000_0058;  // R24 PLL loop filter
        t[19] = 32'h0200_C7D9;  // R25 DAC clock
        t[20] = 32'hAFA8_001A;  // R26 PLL2 charge pump
        t[21] = 32'h1000_001B;  // R27 PLL1 R divider
        t[22] = 32'h0020_009C;  // R28 PLL2 R / PLL1 N
        t[23] = 32'h0180_033D;  // R29 PLL2 N calibration
        t[24] = 32'h0200_033E;  // R30 PLL2 N
        t[25] = 32'h0000_001F;  // R31 uWire lock off
        t[26] = 32'h0014_0300;  // R0 rewrite after PLL2 N so outputs resync
        return t;
    endfunction

    localparam lmk_rom_t LMK_ROM_DEFAULT = lmk_default_rom();

endpackage

// File: rtl/lmk_spi_cfg_if.sv
// lmk_spi_cfg_if: start request, MICROWIRE lines and status between the
// power-up controller (master) and the LMK write engine (slave).
//   spi_initial_start : master -> slave, one-cycle start request
//   lmk_clk/data/le   : slave -> master side, MICROWIRE pins
//   cfg_busy/cfg_done : slave status
//   debug_signal      : slave debug bus
interface lmk_spi_cfg_if;
    logic        spi_initial_start;
    logic        lmk_clk;
    logic        lmk_data;
    logic        lmk_le;
    logic        cfg_busy;
    logic        cfg_done;
    logic [63:0] debug_signal;

    modport slave (
        input  spi_initial_start,
        output lmk_clk, lmk_data, lmk_le, cfg_busy, cfg_done, debug_signal
    );

    modport master (
        output spi_initial_start,
        input  lmk_clk, lmk_data, lmk_le, cfg_busy, cfg_done, debug_signal
    );
endinterface

// File: rtl/lmk_reg_rom.sv
// lmk_reg_rom: combinational register-word table lookup.
//   i_addr   : word number (5 b)
//   o_word_c : 32-bit register word, straight from TABLE
module lmk_reg_rom
    import lmk_cfg_pkg::*;
#(
    parameter lmk_rom_t TABLE = LMK_ROM_DEFAULT
) (
    input  logic [LMK_ADDR_W-1:0] i_addr,
    output logic [LMK_WORD_W-1:0] o_word_c
);

    assign o_word_c = TABLE[i_addr];

endmodule

// File: rtl/lmk_spi_cfg.sv
// lmk_spi_cfg: MICROWIRE write engine for the LMK04806. Each accepted start
// shifts REG_NUM table words MSB first, latches each with an LE pulse, then
// pulses cfg_done.
//   clk_20mhz  : system clock, rising edge
//   sys_rest_n : asynchronous active-low reset
//   bus        : lmk_spi_cfg_if.slave (start in; MICROWIRE, status, debug out)
module lmk_spi_cfg
    import lmk_cfg_pkg::*;
#(
    parameter int unsigned REG_NUM   = LMK_REG_NUM,
    parameter int unsigned CLK_DIV   = 4,
    parameter lmk_rom_t    ROM_TABLE = LMK_ROM_DEFAULT
) (
    input  logic         clk_20mhz,
    input  logic         sys_rest_n,
    lmk_spi_cfg_if.slave bus
);

    // Counter covers 0 .. 2*CLK_DIV-1; one full count is a bit/LE/gap period.
    localparam int unsigned          DIV_W     = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_RISE  = DIV_W'(CLK_DIV - 1);
    localparam logic [LMK_ADDR_W-1:0] LAST_WORD = LMK_ADDR_W'(REG_NUM - 1);
    localparam logic [LMK_IDX_W-1:0]  FIRST_BIT = LMK_IDX_W'(LMK_WORD_W - 1);

    lmk_state_e              r_state;
    logic [LMK_ADDR_W-1:0]   r_word_idx;
    logic [LMK_IDX_W-1:0]    r_bit_idx;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [LMK_WORD_W-1:0]   r_shreg;
    logic                    r_lmk_clk;
    logic                    r_lmk_data;
    logic                    r_lmk_le;
    logic                    r_cfg_busy;
    logic                    r_cfg_done;

    logic [LMK_WORD_W-1:0]   w_rom_word;
    lmk_debug_t              w_debug;

    lmk_reg_rom #(
        .TABLE (ROM_TABLE)
    ) u_rom (
        .i_addr   (r_word_idx),
        .o_word_c (w_rom_word)
    );

    // Write sequencer. r_shreg holds the bits still to go on the wire; the
    // bit currently driven lives in r_lmk_data, so the line is a flop output.
    always_ff @(posedge clk_20mhz or negedge sys_rest_n) begin
        if (!sys_rest_n) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_bit_idx  <= '0;
            r_div_cnt  <= '0;
            r_shreg    <= '0;
            r_lmk_clk  <= 1'b0;
            r_lmk_data <= 1'b0;
            r_lmk_le   <= 1'b0;
            r_cfg_busy <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_lmk_clk  <= 1'b0;
                    r_lmk_data <= 1'b0;
                    r_lmk_le   <= 1'b0;
                    r_cfg_busy <= 1'b0;
                    if (bus.spi_initial_start) begin
                        r_state    <= ST_LOAD;
                        r_word_idx <= '0;
                        r_cfg_busy <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_lmk_data <= w_rom_word[LMK_WORD_W-1];
                    r_shreg    <= {w_rom_word[LMK_WORD_W-2:0], 1'b0};
                    r_bit_idx  <= FIRST_BIT;
                    r_div_cnt  <= '0;
                    r_lmk_clk  <= 1'b0;
                    r_state    <= ST_SHIFT;
                end

                // First half of each period clk low, second half high.
                ST_SHIFT: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_lmk_clk <= 1'b0;
                        r_shreg   <= {r_shreg[LMK_WORD_W-2:0], 1'b0};
                        r_bit_idx <= r_bit_idx - LMK_IDX_W'(1);
                        if (r_bit_idx == '0) begin
                            r_lmk_data <= 1'b0;
                            r_lmk_le   <= 1'b1;
                            r_state    <= ST_LATCH;
                        end else begin
                            r_lmk_data <= r_shreg[LMK_WORD_W-1];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                        r_lmk_clk <= (r_div_cnt >= DIV_RISE);
                    end
                end

                ST_LATCH: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_lmk_le  <= 1'b0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end

                ST_GAP: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        if (r_word_idx == LAST_WORD) begin
                            r_cfg_busy <= 1'b0;
                            r_cfg_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_word_idx <= r_word_idx + LMK_ADDR_W'(1);
                            r_state    <= ST_LOAD;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end

                // Start is deliberately ignored here; next accept is from IDLE.
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_debug = '{
        state:    r_state,
        word_idx: r_word_idx,
        bit_idx:  r_bit_idx,
        lmk_clk:  r_lmk_clk,
        lmk_data: r_lmk_data,
        lmk_le:   r_lmk_le,
        cfg_busy: r_cfg_busy,
        cfg_done: r_cfg_done,
        rsvd:     '0
    };

    assign bus.lmk_clk      = r_lmk_clk;
    assign bus.lmk_data     = r_lmk_data;
    assign bus.lmk_le       = r_lmk_le;
    assign bus.cfg_busy     = r_cfg_busy;
    assign bus.cfg_done     = r_cfg_done;
    assign bus.debug_signal = LMK_DEBUG_W'(w_debug);

endmodule

// File: tb/tb_lmk_spi_cfg.sv
// tb_lmk_spi_cfg: two engines on a 3-word test table, CLK_DIV=2 (dut 0) and
// CLK_DIV=1 (dut 1). A reference model turns each start into expected bits,
// LE widths and a cfg_done edge; a negedge monitor pops and compares.
module tb_lmk_spi_cfg;
    import lmk_cfg_pkg::*;

    localparam int unsigned TB_REG_NUM = 3;

    function automatic lmk_rom_t tb_table();
        lmk_rom_t t;
        t    = '0;
        t[0] = 32'h0002_0000;
        t[1] = 32'hA5A5_0001;
        t[2] = 32'h8000_001F;
        return t;
    endfunction
    localparam lmk_rom_t TB_ROM = tb_table();

    logic [31:0] words [TB_REG_NUM] = '{32'h0002_0000, 32'hA5A5_0001, 32'h8000_001F};

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    int unsigned cyc = 0;

    lmk_spi_cfg_if bus0 ();
    lmk_spi_cfg_if bus1 ();

    lmk_spi_cfg #(.REG_NUM(TB_REG_NUM), .CLK_DIV(2), .ROM_TABLE(TB_ROM)) u_dut0 (
        .clk_20mhz (clk), .sys_rest_n (rst0_n), .bus (bus0.slave));
    lmk_spi_cfg #(.REG_NUM(TB_REG_NUM), .CLK_DIV(1), .ROM_TABLE(TB_ROM)) u_dut1 (
        .clk_20mhz (clk), .sys_rest_n (rst1_n), .bus (bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard / model state, indexed by dut.
    int          vectors = 0;
    int          miscompares = 0;
    bit          exp_bits [2][$];
    int          exp_le   [2][$];
    int unsigned exp_done [2][$];
    int unsigned free_edge [2];
    int unsigned busy_lo [2];
    int unsigned busy_hi [2];
    logic        prev_clk [2];
    logic        prev_le [2];
    logic        prev_data [2];
    int          le_width [2];
    int          captured [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Sampling-edge counts: a start seen at edge T keeps the engine busy at
    // edges T+1 .. T+seq, cfg_done is seen at T+seq+1, restart from T+seq+2.
    function automatic int unsigned seq_len(input int d);
        return TB_REG_NUM * (68 * div_of(d) + 1);
    endfunction

    task automatic model_reset(input int d);
        exp_bits[d].delete();
        exp_le[d].delete();
        exp_done[d].delete();
        free_edge[d] = 0;
        busy_lo[d]   = 1;
        busy_hi[d]   = 0;
        le_width[d]  = 0;
    endtask

    task automatic model_start(input int d, input int unsigned t_edge);
        if (t_edge < free_edge[d]) return;
        for (int w = 0; w < int'(TB_REG_NUM); w++) begin
            for (int b = 31; b >= 0; b--) exp_bits[d].push_back(words[w][b]);
            exp_le[d].push_back(2 * int'(div_of(d)));
        end
        exp_done[d].push_back(t_edge + seq_len(d) + 1);
        busy_lo[d]   = t_edge + 1;
        busy_hi[d]   = t_edge + seq_len(d);
        free_edge[d] = t_edge + seq_len(d) + 2;
    endtask

    // Call at a negedge: the start is sampled by the next posedge.
    task automatic pulse_start(input int d);
        model_start(d, cyc + 1);
        if (d == 0) bus0.spi_initial_start = 1'b1;
        else        bus1.spi_initial_start = 1'b1;
        @(negedge clk);
        bus0.spi_initial_start = 1'b0;
        bus1.spi_initial_start = 1'b0;
    endtask

    task automatic mon_step(input int d, input logic lclk, input logic ldata, input logic lle,
                            input logic busy, input logic done, input logic [63:0] dbg);
        int unsigned samp_edge;
        logic        exp_busy;
        bit          e;
        samp_edge = cyc + 1;
        exp_busy  = (samp_edge >= busy_lo[d]) && (samp_edge <= busy_hi[d]);
        check($sformatf("cfg_busy[%0d]", d), 64'(busy), 64'(exp_busy));
        check($sformatf("dbg_busy[%0d]", d), 64'(dbg[47]), 64'(exp_busy));
        check($sformatf("dbg_rsvd[%0d]", d), 64'(dbg[45:0]), 64'd0);
        if (lclk && !prev_clk[d]) begin
            if (exp_bits[d].size() == 0) begin
                flag($sformatf("lmk_clk_rise[%0d]", d));
            end else begin
                e = exp_bits[d].pop_front();
                check($sformatf("lmk_data[%0d] bit %0d", d, captured[d]), 64'(ldata), 64'(e));
                check($sformatf("data_setup[%0d]", d), 64'(ldata), 64'(prev_data[d]));
                captured[d]++;
            end
        end
        if (lle && !prev_le[d]) check($sformatf("le_clk_low[%0d]", d), 64'(lclk), 64'd0);
        if (lle) le_width[d]++;
        if (!lle && prev_le[d]) begin
            if (exp_le[d].size() == 0) flag($sformatf("lmk_le_pulse[%0d]", d));
            else check($sformatf("le_width[%0d]", d), 64'(le_width[d]), 64'(exp_le[d].pop_front()));
            le_width[d] = 0;
        end
        if (done) begin
            if (exp_done[d].size() == 0) flag($sformatf("cfg_done[%0d]", d));
            else check($sformatf("cfg_done_edge[%0d]", d), 64'(samp_edge), 64'(exp_done[d].pop_front()));
        end
        prev_clk[d]  = lclk;
        prev_le[d]   = lle;
        prev_data[d] = ldata;
    endtask

    always @(negedge clk) begin
        mon_step(0, bus0.lmk_clk, bus0.lmk_data, bus0.lmk_le, bus0.cfg_busy, bus0.cfg_done, bus0.debug_signal);
        mon_step(1, bus1.lmk_clk, bus1.lmk_data, bus1.lmk_le, bus1.cfg_busy, bus1.cfg_done, bus1.debug_signal);
    end

    task automatic drain(input int d);
        int n;
        n = 0;
        while (exp_done[d].size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check($sformatf("drain_done[%0d]", d), 64'(exp_done[d].size()), 64'd0);
        check($sformatf("drain_bits[%0d]", d), 64'(exp_bits[d].size()), 64'd0);
        check($sformatf("drain_le[%0d]", d), 64'(exp_le[d].size()), 64'd0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_lines0"}, 64'({bus0.lmk_clk, bus0.lmk_data, bus0.lmk_le, bus0.cfg_busy, bus0.cfg_done}), 64'd0);
        check({name, "_dbg0"}, bus0.debug_signal, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            prev_clk[d] = 1'b0; prev_le[d] = 1'b0; prev_data[d] = 1'b0; captured[d] = 0;
        end
        // Reset held with start asserted: everything stays low.
        bus0.spi_initial_start = 1'b1;
        bus1.spi_initial_start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_quiet("reset_hold");
            check("reset_hold_lines1", 64'({bus1.lmk_clk, bus1.lmk_data, bus1.lmk_le, bus1.cfg_busy, bus1.cfg_done}), 64'd0);
            check("reset_hold_dbg1", bus1.debug_signal, 64'd0);
        end
        bus0.spi_initial_start = 1'b0;
        bus1.spi_initial_start = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic sequence on both engines.
        c0 = captured[0];
        pulse_start(0);
        pulse_start(1);
        drain(0);
        drain(1);
        check("basic_bits0", 64'(captured[0] - c0), 64'd96);

        // Second start lands 100 edges after the first, while busy.
        c0 = captured[0];
        pulse_start(0);
        repeat (99) @(negedge clk);
        pulse_start(0);
        drain(0);
        check("busy_start_bits0", 64'(captured[0] - c0), 64'd96);

        // Start during DONE is ignored; the very next edge accepts.
        pulse_start(0);
        n = 0;
        while (!bus0.cfg_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen0", 64'(bus0.cfg_done), 64'd1);
        pulse_start(0);
        pulse_start(0);
        drain(0);

        // Reset in word 1, bit 10: lines drop at once, replay is from word 0.
        c0 = captured[0];
        pulse_start(0);
        n = 0;
        while (captured[0] < c0 + 53 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("bits_before_reset", 64'(captured[0] - c0), 64'd53);
        repeat (2) @(negedge clk);
        #3;
        rst0_n = 1'b0;
        model_reset(0);
        #1;
        check_quiet("async_reset");
        repeat (4) @(negedge clk);
        check_quiet("reset_mid");
        rst0_n = 1'b1;
        @(negedge clk);
        c0 = captured[0];
        pulse_start(0);
        drain(0);
        check("replay_bits0", 64'(captured[0] - c0), 64'd96);

        // Random starts on either engine, many landing while busy.
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            pulse_start(int'($urandom_range(0, 1)));
        end
        drain(0);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
